// File: rtl/reaction_round_controller_pkg.sv
// Shared definitions for the reaction timer: round state codes, time width and
// the LFSR step function used by the hold-off generator.
package reaction_round_controller_pkg;

  localparam int TIME_W           = 14;
  localparam int MAX_TIME_DEFAULT = 9999;

  typedef enum logic [2:0] {
    STATE_IDLE      = 3'd0,
    STATE_WAIT      = 3'd1,
    STATE_GO        = 3'd2,
    STATE_RESULT_OK = 3'd3,
    STATE_TOO_EARLY = 3'd4,
    STATE_TIMEOUT   = 3'd5
  } state_e;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
  endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that supplies the random hold-off offset.
module reaction_lfsr
  import reaction_round_controller_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;

  // Advance every clock; reload the seed while reset is held low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/reaction_round_controller.sv
// Round sequencer for the reaction timer: random hold-off, GO light and ms timing.
// Optional macro REACTION_TIMEOUT_EN ends the round in TIMEOUT when the count reaches MAX_TIME.
module reaction_round_controller
  import reaction_round_controller_pkg::*;
#(
  parameter int          DELAY_MIN_MS  = 1000,
  parameter int          DELAY_SPAN_MS = 4096,
  parameter int          MAX_TIME      = MAX_TIME_DEFAULT,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick_1ms,
  input  logic              start_btn,
  input  logic              react_btn,
  output logic [2:0]        current_state,
  output logic [TIME_W-1:0] reaction_time,
  output logic              go_led,
  output logic              busy
);

  localparam logic [TIME_W-1:0] MAX_T     = TIME_W'(MAX_TIME);
  localparam logic [15:0]       DMIN      = 16'(DELAY_MIN_MS);
  localparam logic [15:0]       SPAN_MASK = 16'(DELAY_SPAN_MS - 1);

  state_e            state_r, state_next;
  logic [TIME_W-1:0] time_r, time_next;
  logic [15:0]       delay_r, delay_next;
  logic [15:0]       lfsr_value;
  logic              go_led_r, busy_r;

  reaction_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_value)
  );

  // Next-state, hold-off countdown and reaction-time arithmetic.
  always_comb begin
    state_next = state_r;
    time_next  = time_r;
    delay_next = delay_r;
    case (state_r)
      STATE_IDLE, STATE_RESULT_OK, STATE_TOO_EARLY, STATE_TIMEOUT: begin
        if (start_btn) begin
          state_next = STATE_WAIT;
          delay_next = DMIN + (lfsr_value & SPAN_MASK);
          time_next  = {TIME_W{1'b0}};
        end else begin
          state_next = state_r;
        end
      end
      STATE_WAIT: begin
        if (react_btn) begin
          state_next = STATE_TOO_EARLY;
        end else if (tick_1ms) begin
          // Treat a zero count like the final tick so a zero hold-off cannot wrap.
          if (delay_r <= 16'd1) begin
            state_next = STATE_GO;
            delay_next = 16'd0;
            time_next  = {TIME_W{1'b0}};
          end else begin
            delay_next = delay_r - 16'd1;
          end
        end else begin
          state_next = STATE_WAIT;
        end
      end
      STATE_GO: begin
        if (react_btn) begin
          state_next = STATE_RESULT_OK;
        end else if (tick_1ms) begin
          if (time_r >= MAX_T) begin
            time_next = MAX_T;
          end else begin
            time_next = time_r + 14'd1;
`ifdef REACTION_TIMEOUT_EN
            if ((time_r + 14'd1) == MAX_T) begin
              state_next = STATE_TIMEOUT;
            end else begin
              state_next = STATE_GO;
            end
`endif
          end
        end else begin
          state_next = STATE_GO;
        end
      end
      default: begin
        state_next = STATE_IDLE;
      end
    endcase
  end

  // State, counters and decoded indicator registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= STATE_IDLE;
      time_r   <= {TIME_W{1'b0}};
      delay_r  <= 16'd0;
      go_led_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next;
      time_r   <= time_next;
      delay_r  <= delay_next;
      go_led_r <= (state_next == STATE_GO);
      busy_r   <= (state_next == STATE_WAIT) || (state_next == STATE_GO);
    end
  end

  assign current_state = state_r;
  assign reaction_time = time_r;
  assign go_led        = go_led_r;
  assign busy          = busy_r;

endmodule
